// File: rtl/ex_muldiv_ctrl.sv
// Iterative MIPS multiply/divide sequencer owning HI/LO; one datapath bit per cycle.
// Define MULDIV_EARLY_TERM_EN to end multiplies once the remaining multiplier is zero.
module ex_muldiv_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   input  logic             flush,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] result
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;

   typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
   state_t state, state_nx;

   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   opb;
   logic [WIDTH-1:0]   hi_r, lo_r;
   logic               op_div, q_neg, r_neg, dbz_r;

   function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v, input logic sgn);
      return (sgn && v < 0) ? WIDTH'(-v) : WIDTH'(v);
   endfunction

   function automatic logic [WIDTH-1:0] fix_w(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] fix_2w(input logic [2*WIDTH-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   logic is_mul, is_div, is_op, is_class, is_signed, rt_zero, accept;
   logic mul_last, div_last;
   logic signed [WIDTH-1:0] rs_s, rt_s;
   logic [WIDTH:0] rem_sh, diff;

   assign rs_s      = rs;
   assign rt_s      = rt;
   assign is_mul    = (funct == F_MULT) || (funct == F_MULTU);
   assign is_div    = (funct == F_DIV) || (funct == F_DIVU);
   assign is_op     = is_mul || is_div;
   assign is_class  = is_op || (funct == F_MFHI) || (funct == F_MTHI) ||
                      (funct == F_MFLO) || (funct == F_MTLO);
   assign is_signed = (funct == F_MULT) || (funct == F_DIV);
   assign rt_zero   = (rt == '0);

   assign busy        = (state == MUL) || (state == DIV) || (state == FIX);
   assign done        = (state == DONE);
   assign div_by_zero = (state == DONE) && dbz_r;
   assign stall       = valid && busy && is_class;
   assign accept      = valid && !busy && is_op;
   assign hi          = hi_r;
   assign lo          = lo_r;

   // Restoring divide: the remainder gets one extra bit so the trial subtract never overflows
   assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
   assign diff     = rem_sh - {1'b0, opb};
   assign div_last = (cnt == CW'(WIDTH - 1));
`ifdef MULDIV_EARLY_TERM_EN
   assign mul_last = (cnt == CW'(WIDTH - 1)) || (opb[WIDTH-1:1] == '0);
`else
   assign mul_last = (cnt == CW'(WIDTH - 1));
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: begin
            if (!accept)                 state_nx = IDLE;
            else if (is_div && rt_zero)  state_nx = DONE;
            else if (is_div)             state_nx = DIV;
            else                         state_nx = MUL;
         end
         MUL:     if (flush) state_nx = IDLE; else if (mul_last) state_nx = FIX;
         DIV:     if (flush) state_nx = IDLE; else if (div_last) state_nx = FIX;
         FIX:     state_nx = flush ? IDLE : DONE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      result = '0;
      if (valid && !busy) begin
         if (funct == F_MFHI)      result = hi_r;
         else if (funct == F_MFLO) result = lo_r;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         opb    <= '0;
         op_div <= 1'b0;
         q_neg  <= 1'b0;
         r_neg  <= 1'b0;
         dbz_r  <= 1'b0;
         hi_r   <= '0;
         lo_r   <= '0;
      end else begin
         if (accept) begin
            cnt    <= '0;
            op_div <= is_div;
            dbz_r  <= is_div && rt_zero;
            q_neg  <= is_signed && (rs[WIDTH-1] ^ rt[WIDTH-1]);
            r_neg  <= is_signed && rs[WIDTH-1];
            opb    <= mag(rt_s, is_signed);
            if (is_div) begin
               acc   <= {{WIDTH{1'b0}}, mag(rs_s, is_signed)};
               mcand <= '0;
            end else begin
               acc   <= '0;
               mcand <= {{WIDTH{1'b0}}, mag(rs_s, is_signed)};
            end
         end else if (state == MUL) begin
            if (opb[0]) acc <= acc + mcand;
            mcand <= mcand << 1;
            opb   <= opb >> 1;
            cnt   <= cnt + CW'(1);
         end else if (state == DIV) begin
            if (diff[WIDTH]) acc <= {acc[2*WIDTH-2:0], 1'b0};
            else             acc <= {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            cnt <= cnt + CW'(1);
         end

         // HI/LO: results land on the FIX edge; moves only happen while not busy
         if (state == FIX && !flush) begin
            if (op_div) begin
               lo_r <= fix_w(acc[WIDTH-1:0], q_neg);
               hi_r <= fix_w(acc[2*WIDTH-1:WIDTH], r_neg);
            end else begin
               {hi_r, lo_r} <= fix_2w(acc, q_neg);
            end
         end else if (valid && !busy && funct == F_MTHI) begin
            hi_r <= rs;
         end else if (valid && !busy && funct == F_MTLO) begin
            lo_r <= rs;
         end
      end
   end
endmodule

// File: doc/ex_muldiv_ctrl.md
Name: ex_muldiv_ctrl

Overview:
Iterative multiply/divide sequencer sitting beside the EX-stage ALU of the 5-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU, runs a shared shift-add/restoring-divide datapath one bit per cycle, and owns the HI/LO registers. It serves MFHI/MFLO/MTHI/MTLO and raises a stall to the pipeline while an operation is in flight.

Parameters:
WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-low; 0 clears all state
valid  input  1  EX holds a muldiv-class instruction (funct below)
funct  input  6  MIPS funct: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011
rs  input  WIDTH  operand A / dividend / MTHI-MTLO source
rt  input  WIDTH  operand B / divisor
flush  input  1  abort the in-flight op (branch redirect)
stall  output  1  freeze IF/ID/EX this cycle
busy  output  1  iteration in progress
done  output  1  one-cycle pulse: HI/LO just updated by mul/div
div_by_zero  output  1  pulses with done when DIV/DIVU had rt==0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
result  output  WIDTH  MFHI/MFLO read data to EX result mux

Behaviour:
- Reset (reset==0, any time incl. mid-op): state=IDLE; hi, lo, counter, shadow regs = 0; busy, done, div_by_zero = 0. The op in flight is discarded.
- States: IDLE, MUL, DIV, FIX, DONE. busy=1 in MUL, DIV and FIX only.
- Accept: valid && !busy && funct in {MULT,MULTU,DIV,DIVU}, in IDLE or DONE (back-to-back allowed). Acceptance edge E0 latches operand magnitudes and the result sign (signed ops: sign = rs[31]^rt[31]; remainder sign = rs[31]), clears the counter, and moves to MUL or DIV.
- MUL/DIV: one iteration per edge E1..E32. Counter 0..31; at count==31 move to FIX.
- FIX (edge E33): apply two's-complement sign correction; write hi/lo (MUL: 64-bit product {hi,lo}; DIV: lo=quotient, hi=remainder); move to DONE with done=1 for that cycle.
- DONE: hi/lo visible. With no new accept, the next edge returns to IDLE. Latency from acceptance edge to done high is 33 edges.
- DIV/DIVU with rt==0: E0 goes straight to DONE; hi/lo unchanged; done=1 and div_by_zero=1 for one cycle.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0. No trap.
- stall = valid && busy, for any muldiv-class funct, including a new MULT/DIV, MFHI/MFLO or MTHI/MTLO. Combinational; it drops in the DONE cycle.
- MTHI/MTLO: when valid && !busy, write rs into hi/lo at that edge. One cycle; no done pulse.
- result = hi (MFHI) or lo (MFLO) when valid && !busy; otherwise 0. In the DONE cycle MFHI/MFLO return the new values.
- flush: in MUL/DIV/FIX, the next edge goes to IDLE, hi/lo stay unchanged, done stays 0. In the same cycle, flush has priority over accept; flush in IDLE/DONE has no effect.
- Non-muldiv funct with valid=1 is ignored; stall=0.

Optional Feature:
MULDIV_EARLY_TERM_EN
- Defined: MUL ends iteration once the remaining multiplier magnitude is 0, going to FIX on the following edge. Iterations = max(1, bit length of |rt|). Latency = iterations+1 edges. DIV is unchanged.
- Undefined: fixed 32 iterations for every multiply.

Test Plan:
- MULT rs=5, rt=5 -> stall=1 for 33 cycles, then done at E33, hi=0, lo=25. With MULDIV_EARLY_TERM_EN: done at E4.
- MULT rs=-3, rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU rs=0xFFFFFFFF, rt=2 -> hi=1, lo=0xFFFFFFFE.
- DIVU rs=100, rt=7 -> lo=14, hi=2. DIV rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV rs=0x80000000, rt=-1 -> lo=0x80000000, hi=0.
- DIV rs=9, rt=0 -> done and div_by_zero high one cycle after E0; hi/lo unchanged.
- MFHI presented at E5 of a MULT -> stall held until the DONE cycle, then result equals the new hi. MTLO rs=0x1234 when idle -> lo=0x1234 next edge.
- flush at E10 of a DIVU -> IDLE next edge, done never asserted, hi/lo unchanged. reset low at E20 of a MULT -> all outputs 0 immediately.
